// File: rtl/debug_console_pkg.sv
// Shared types and constants for the debug console controller.
//   uart_state_t       : UART transmitter states
//   ASCII_LF           : newline character, written by the CPU or inserted automatically
//   DEFAULT_DEBUG_ADDR : default bus address of the console data register
package debug_console_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [7:0]  ASCII_LF           = 8'h0A;
  localparam logic [31:0] DEFAULT_DEBUG_ADDR = 32'hf000_00d0;

endpackage

// File: rtl/debug_console_if.sv
// CPU data-bus view of the debug console.
//   address    : CPU data bus address
//   data_write : store data, character in [31:24]
//   data_we    : byte write enables, any bit set marks a store
//   stall_sig  : stall request back to the CPU
// master = CPU side, slave = console side.
interface debug_console_if;

  logic [31:0] address;
  logic [31:0] data_write;
  logic [3:0]  data_we;
  logic        stall_sig;

  modport master (output address, output data_write, output data_we, input stall_sig);
  modport slave  (input address, input data_write, input data_we, output stall_sig);

endinterface

// File: rtl/console_fifo.sv
// Character buffer between the bus capture logic and the UART.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop, dout  : dout shows the head; pop advances it
//   full, empty, level : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module console_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

endmodule

// File: rtl/debug_console_ctrl.sv
// Debug console: captures CPU byte stores to DEBUG_ADDR, inserts a newline
// after LINE_MAX characters on a line, buffers characters and sends them
// as 8N1 UART frames.
//   clock_in, reset_n : clock, asynchronous active-low reset
//   bus               : CPU store interface (slave side), drives stall_sig
//   uart_tx           : serial output, idles high
//   tx_busy           : transmitter not idle
//   fifo_level        : buffer occupancy
//   char_valid/char_out : one-cycle report of each character entering the buffer
module debug_console_ctrl
  import debug_console_pkg::*;
#(
  parameter logic [31:0] DEBUG_ADDR = DEFAULT_DEBUG_ADDR,
  parameter int          FIFO_DEPTH = 16,
  parameter int          LINE_MAX   = 72,
  parameter int          BAUD_DIV   = 434
) (
  input  logic                         clock_in,
  input  logic                         reset_n,
  debug_console_if.slave               bus,
  output logic                         uart_tx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         char_valid,
  output logic [7:0]                   char_out
);

  localparam int COL_W = $clog2(LINE_MAX + 1);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic       hit, accept, nl_push, push, pop;
  logic       full, empty;
  logic [7:0] cpu_char, push_char, fifo_head;
  logic       pending_nl;
  logic [COL_W-1:0] column;
  logic       vld_p1;
  logic [7:0] char_p1;
  logic       unused_low_bytes;

  uart_state_t      state, state_n;
  logic [CNT_W-1:0] baud_cnt, cnt_n;
  logic [2:0]       bit_idx, idx_n;
  logic [7:0]       shreg;
  logic             baud_end;

  assign cpu_char         = bus.data_write[31:24];
  assign unused_low_bytes = ^bus.data_write[23:0];

  // Stall uses the registered full flag; a pending newline also blocks the
  // CPU so the newline lands in the buffer before the next character.
  assign hit           = (bus.address == DEBUG_ADDR) && (|bus.data_we);
  assign bus.stall_sig = reset_n && hit && (full || pending_nl);
  assign accept        = hit && !full && !pending_nl;
  assign nl_push       = pending_nl && !full;
  assign push          = accept || nl_push;
  assign push_char     = nl_push ? ASCII_LF : cpu_char;

  console_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clock_in),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (push_char),
    .dout  (fifo_head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Column tracking on accepted CPU characters.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      column     <= '0;
      pending_nl <= 1'b0;
    end else if (nl_push) begin
      pending_nl <= 1'b0;
    end else if (accept) begin
      if (cpu_char == ASCII_LF) begin
        column <= '0;
      end else if (column == COL_LAST) begin
        column     <= '0;
        pending_nl <= 1'b1;
      end else begin
        column <= column + 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: push report ----
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      char_p1 <= '0;
    end else begin
      vld_p1 <= push;
      if (push) char_p1 <= push_char;
    end
  end

  assign char_valid = vld_p1;
  assign char_out   = char_p1;

  // UART transmitter
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_idx  <= idx_n;
    end
  end

  always_ff @(posedge clock_in) begin
    if (pop) shreg <= fifo_head;
  end

  assign baud_end = (baud_cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = baud_cnt;
    idx_n   = bit_idx;
    pop     = 1'b0;
    uart_tx = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        uart_tx = shreg[bit_idx];
        if (baud_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 idx_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          cnt_n = '0;
          // Chain straight into the next frame so there is no idle bit.
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule
